// File: rtl/tetris_collision_checker.sv
// ============================================================================
// Module   : tetris_collision_checker
// Brief    : Walks the four cells of a candidate piece, bounds-checks each cell,
//            reads board occupancy and reports whether the piece collides.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tetris_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int X_W     = 4,
    parameter int Y_W     = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req,
    input  logic [2:0]     req_shape,
    input  logic [1:0]     req_rot,
    input  logic [X_W-1:0] req_px,
    input  logic [Y_W-1:0] req_py,
    output logic [2:0]     off_shape,
    output logic [1:0]     off_rot,
    input  logic [1:0]     dx0,
    input  logic [1:0]     dx1,
    input  logic [1:0]     dx2,
    input  logic [1:0]     dx3,
    input  logic [1:0]     dy0,
    input  logic [1:0]     dy1,
    input  logic [1:0]     dy2,
    input  logic [1:0]     dy3,
    output logic           rd_en,
    output logic [X_W-1:0] rd_x,
    output logic [Y_W-1:0] rd_y,
    input  logic           rd_data,
    output logic           busy,
    output logic           done,
    output logic           collide
);

    localparam logic [X_W:0] c_board_w = (X_W+1)'(BOARD_W);
    localparam logic [Y_W:0] c_board_h = (Y_W+1)'(BOARD_H);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [X_W-1:0]  r_px;
    logic [Y_W-1:0]  r_py;
    logic [3:0][1:0] r_dx;
    logic [3:0][1:0] r_dy;
    logic            r_oob;

    logic [3:0][1:0] w_dx_in;
    logic [3:0][1:0] w_dy_in;
    logic [1:0]      w_nidx;
    logic [1:0]      w_ndx;
    logic [1:0]      w_ndy;
    logic [X_W:0]    w_bx;
    logic [Y_W:0]    w_by;
    logic            w_in_bounds;

    assign w_dx_in = {dx3, dx2, dx1, dx0};
    assign w_dy_in = {dy3, dy2, dy1, dy0};

    // Address of the cell about to be issued. Coming out of LATCH the offsets
    // are not registered yet, so they are taken straight from the table.
    always_comb begin
        w_nidx      = (r_state == S_LATCH) ? 2'd0 : r_idx + 2'd1;
        w_ndx       = (r_state == S_LATCH) ? w_dx_in[0] : r_dx[w_nidx];
        w_ndy       = (r_state == S_LATCH) ? w_dy_in[0] : r_dy[w_nidx];
        w_bx        = {1'b0, r_px} + (X_W+1)'(w_ndx);
        w_by        = {1'b0, r_py} + (Y_W+1)'(w_ndy);
        w_in_bounds = (w_bx < c_board_w) && (w_by < c_board_h);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_px      <= '0;
            r_py      <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_oob     <= 1'b0;
            off_shape <= 3'd0;
            off_rot   <= 2'd0;
            rd_en     <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collide   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        off_shape <= req_shape;
                        off_rot   <= req_rot;
                        r_px      <= req_px;
                        r_py      <= req_py;
                        r_idx     <= 2'd0;
                        collide   <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_dx    <= w_dx_in;
                    r_dy    <= w_dy_in;
                    r_idx   <= w_nidx;
                    rd_en   <= w_in_bounds;
                    r_oob   <= !w_in_bounds;
                    if (w_in_bounds) begin
                        rd_x <= w_bx[X_W-1:0];
                        rd_y <= w_by[Y_W-1:0];
                    end
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    rd_en <= 1'b0;
                    if (r_oob) begin
                        collide <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd_data) begin
                        collide <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_idx == 2'd3) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= w_nidx;
                        rd_en   <= w_in_bounds;
                        r_oob   <= !w_in_bounds;
                        if (w_in_bounds) begin
                            rd_x <= w_bx[X_W-1:0];
                            rd_y <= w_by[Y_W-1:0];
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tetris_collision_checker.sv
// ============================================================================
// Module   : tb_tetris_collision_checker
// Brief    : Self-checking bench with offset-table and board-memory models.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tetris_collision_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [2:0] req_shape;
    logic [1:0] req_rot;
    logic [3:0] req_px;
    logic [4:0] req_py;
    logic [2:0] off_shape;
    logic [1:0] off_rot;
    logic [1:0] dx0, dx1, dx2, dx3, dy0, dy1, dy2, dy3;
    logic       rd_en;
    logic [3:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_data;
    logic       busy, done, collide;

    int n_asserts = 0;
    int n_fail    = 0;

    bit board [20][10];

    always #5 clk = ~clk;

    tetris_collision_checker dut (
        .clk(clk), .reset(reset), .req(req),
        .req_shape(req_shape), .req_rot(req_rot), .req_px(req_px), .req_py(req_py),
        .off_shape(off_shape), .off_rot(off_rot),
        .dx0(dx0), .dx1(dx1), .dx2(dx2), .dx3(dx3),
        .dy0(dy0), .dy1(dy1), .dy2(dy2), .dy3(dy3),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .busy(busy), .done(done), .collide(collide)
    );

    // Piece offsets, cell i packed at [2i+:2]. 0=O, 1=I, 2=T, 3=S, others zero.
    function automatic void get_offs(input logic [2:0] s, input logic [1:0] r,
                                     output logic [7:0] dxv, output logic [7:0] dyv);
        dxv = 8'd0;
        dyv = 8'd0;
        case (s)
            3'd0: begin dxv = {2'd2, 2'd1, 2'd2, 2'd1}; dyv = {2'd2, 2'd2, 2'd1, 2'd1}; end
            3'd1: if (r[0]) dxv = {2'd3, 2'd2, 2'd1, 2'd0};
                  else      dyv = {2'd3, 2'd2, 2'd1, 2'd0};
            3'd2: if (r[0]) begin dxv = {2'd0, 2'd1, 2'd1, 2'd1}; dyv = {2'd1, 2'd2, 2'd1, 2'd0}; end
                  else      begin dxv = {2'd1, 2'd2, 2'd1, 2'd0}; dyv = {2'd1, 2'd0, 2'd0, 2'd0}; end
            3'd3: begin dxv = {2'd1, 2'd0, 2'd2, 2'd1}; dyv = {2'd1, 2'd1, 2'd0, 2'd0}; end
            default: ;
        endcase
    endfunction

    logic [7:0] tdx, tdy;
    always_comb begin
        get_offs(off_shape, off_rot, tdx, tdy);
    end
    assign {dx3, dx2, dx1, dx0} = tdx;
    assign {dy3, dy2, dy1, dy0} = tdy;

    // Board memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en && rd_x < 4'd10 && rd_y < 5'd20)
            rd_data <= board[rd_y][rd_x];
        else
            rd_data <= 1'b0;
    end

    task automatic clear_board();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = 1'b0;
    endtask

    // One request, accepted in the current cycle (bench sits at a negedge, DUT idle).
    task automatic run_req(input logic [2:0] s, input logic [1:0] r,
                           input int x, input int y, input bit interfere, input string name);
        logic [7:0] odx, ody;
        int  exp_lat, done_j, bx, by;
        bit  exp_col, prev_en, stop;
        int  exp_rd[$];
        int  got_rd[$];
        get_offs(s, r, odx, ody);
        exp_lat = 10;
        exp_col = 1'b0;
        stop    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!stop) begin
                bx = x + int'(odx[2*i +: 2]);
                by = y + int'(ody[2*i +: 2]);
                if (bx >= 10 || by >= 20) begin
                    exp_col = 1'b1; exp_lat = 3 + 2*i; stop = 1'b1;
                end else begin
                    exp_rd.push_back(((2 + 2*i) << 16) | (by << 8) | bx);
                    if (board[by][bx]) begin
                        exp_col = 1'b1; exp_lat = 4 + 2*i; stop = 1'b1;
                    end
                end
            end
        end

        req = 1'b1; req_shape = s; req_rot = r; req_px = 4'(x); req_py = 5'(y);
        done_j  = 0;
        prev_en = 1'b0;
        for (int j = 1; j <= 16 && done_j == 0; j++) begin
            @(negedge clk);
            req = 1'b0;
            if (interfere && j == 3) begin
                req = 1'b1; req_shape = ~s; req_rot = ~r; req_px = 4'd0; req_py = 5'd19;
            end
            if (rd_en) got_rd.push_back((j << 16) | (int'(rd_y) << 8) | int'(rd_x));
            n_asserts++;
            if (prev_en && rd_en) begin
                n_fail++; $display("FAIL %s rd_en_consecutive at j=%0d", name, j);
            end
            prev_en = rd_en;
            n_asserts++;
            if ({off_shape, off_rot} !== {s, r}) begin
                n_fail++; $display("FAIL %s off_sel j=%0d got %0d/%0d want %0d/%0d", name, j, off_shape, off_rot, s, r);
            end
            if (j == 1) begin
                n_asserts++;
                if (collide !== 1'b0) begin
                    n_fail++; $display("FAIL %s collide_clear got %b want 0", name, collide);
                end
            end
            if (done === 1'b1) done_j = j;
            n_asserts++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL %s busy j=%0d got %b want 1", name, j, busy);
            end
        end
        req = 1'b0;

        n_asserts++;
        if (done_j != exp_lat) begin
            n_fail++; $display("FAIL %s latency got %0d want %0d", name, done_j, exp_lat);
        end
        n_asserts++;
        if (collide !== exp_col) begin
            n_fail++; $display("FAIL %s collide got %b want %b", name, collide, exp_col);
        end
        n_asserts++;
        if (got_rd.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL %s read_count got %0d want %0d", name, got_rd.size(), exp_rd.size());
        end else begin
            foreach (exp_rd[k]) begin
                n_asserts++;
                if (got_rd[k] != exp_rd[k]) begin
                    n_fail++; $display("FAIL %s read%0d got %h want %h", name, k, got_rd[k], exp_rd[k]);
                end
            end
        end

        @(negedge clk);
        n_asserts++;
        if ({busy, done, collide} !== {2'b00, exp_col}) begin
            n_fail++; $display("FAIL %s after_done busy/done/collide got %b%b%b want 00%b", name, busy, done, collide, exp_col);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_asserts++;
        if ({busy, done, collide, rd_en, rd_x, rd_y, off_shape, off_rot} !== 18'd0) begin
            n_fail++; $display("FAIL reset outputs got b%b d%b c%b e%b x%0d y%0d s%0d r%0d want all 0",
                               busy, done, collide, rd_en, rd_x, rd_y, off_shape, off_rot);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        clear_board();
        run_req(3'd0, 2'd0, 0, 0, 1'b0, "o_empty");
        run_req(3'd1, 2'd1, 7, 0, 1'b0, "i_right_oob");
        run_req(3'd1, 2'd0, 4, 17, 1'b0, "i_bottom_oob");
        board[3][5] = 1'b1;
        run_req(3'd1, 2'd0, 5, 2, 1'b0, "i_hit");
        run_req(3'd7, 2'd2, 9, 19, 1'b0, "unknown_shape");
        clear_board();
    endtask

    task automatic test_busy_ignore();
        clear_board();
        run_req(3'd2, 2'd1, 3, 6, 1'b1, "busy_ignore");
        board[7][4] = 1'b1;
        run_req(3'd2, 2'd0, 3, 6, 1'b0, "back_to_back");
        clear_board();
    endtask

    task automatic test_reset_mid();
        clear_board();
        board[2][1] = 1'b1;
        req = 1'b1; req_shape = 3'd0; req_rot = 2'd0; req_px = 4'd0; req_py = 5'd0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            req = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_asserts++;
        if ({busy, rd_en, done, collide} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid got b%b e%b d%b c%b want 0000", busy, rd_en, done, collide);
        end
        @(negedge clk);
        n_asserts++;
        if ({busy, done, collide} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_stale got b%b d%b c%b want 000", busy, done, collide);
        end
        clear_board();
        run_req(3'd0, 2'd0, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int y = 0; y < 20; y++)
                for (int x = 0; x < 10; x++)
                    board[y][x] = ($urandom_range(0, 5) == 0);
            run_req(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 11)), int'($urandom_range(0, 21)), 1'b0, "random");
        end
        clear_board();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_shape = 3'd0; req_rot = 2'd0; req_px = 4'd0; req_py = 5'd0;
        clear_board();
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
